// File: rtl/retire_unit.sv
// retire_unit: in-order retirement buffer for a two-wide dispatch machine.
//
// Entries are allocated at the tail by dispatch, marked done by execution
// completion reports, and retired from the head in program order, at most
// two per cycle. Retiring an entry hands its superseded physical register
// back to the renamer through registered free outputs.
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   alloc0_i / alloc1_i             dispatch slot 0/1 requests an entry
//   has_old0_i / has_old1_i         slot carries an old preg to free
//   old_dest0_i / old_dest1_i       superseded preg for each slot
//   cmpl_en0_i/1_i, cmpl_tag0_i/1_i completion reports
//   tag0_o / tag1_o                 tags handed to slot 0 / slot 1
//   rob_full_o / rob_empty_o        occupancy status
//   en_free_reg0_o/1_o, free_reg0_o/1_o  registered free requests
module retire_unit #(
  parameter int NUM_P_REGS = 64,
  parameter int ROB_DEPTH  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          alloc0_i,
  input  logic                          alloc1_i,
  input  logic                          has_old0_i,
  input  logic                          has_old1_i,
  input  logic [$clog2(NUM_P_REGS)-1:0] old_dest0_i,
  input  logic [$clog2(NUM_P_REGS)-1:0] old_dest1_i,
  input  logic                          cmpl_en0_i,
  input  logic                          cmpl_en1_i,
  input  logic [$clog2(ROB_DEPTH)-1:0]  cmpl_tag0_i,
  input  logic [$clog2(ROB_DEPTH)-1:0]  cmpl_tag1_i,
  output logic [$clog2(ROB_DEPTH)-1:0]  tag0_o,
  output logic [$clog2(ROB_DEPTH)-1:0]  tag1_o,
  output logic                          rob_full_o,
  output logic                          rob_empty_o,
  output logic                          en_free_reg0_o,
  output logic                          en_free_reg1_o,
  output logic [$clog2(NUM_P_REGS)-1:0] free_reg0_o,
  output logic [$clog2(NUM_P_REGS)-1:0] free_reg1_o
);

  localparam int TW = $clog2(ROB_DEPTH);
  localparam int PW = $clog2(NUM_P_REGS);
  localparam int CW = $clog2(ROB_DEPTH + 1);

  logic [TW-1:0]        head_reg, tail_reg;
  logic [CW-1:0]        count_reg;
  logic [ROB_DEPTH-1:0] valid_reg, valid_next;
  logic [ROB_DEPTH-1:0] done_reg, done_next;
  logic [ROB_DEPTH-1:0] has_old_reg;
  logic [PW-1:0]        old_dest_reg [ROB_DEPTH];

  logic          acc0, acc1;
  logic          ret0, ret1;
  logic [TW-1:0] head1;
  logic [TW-1:0] wa0, wa1;

  // Full leaves room for a whole two-wide group, so dispatch is all-or-nothing.
  assign rob_full_o  = count_reg > CW'(ROB_DEPTH - 2);
  assign rob_empty_o = (count_reg == '0);

  assign acc0 = alloc0_i & ~rob_full_o;
  assign acc1 = alloc1_i & ~rob_full_o;

  // Slot 1 packs down to the tail when slot 0 is idle.
  assign wa0 = tail_reg;
  assign wa1 = tail_reg + TW'(acc0);

  assign tag0_o = tail_reg;
  assign tag1_o = tail_reg + TW'(alloc0_i);

  assign head1 = head_reg + TW'(1);
  assign ret0  = valid_reg[head_reg] & done_reg[head_reg];
  assign ret1  = ret0 & valid_reg[head1] & done_reg[head1];

  // Per-entry next-state for the valid/done flags. Allocation can never hit
  // an entry that is retiring or valid, because fullness reserves two slots.
  for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
    logic hit_ret, hit_wr, hit_cmpl;
    assign hit_ret  = (ret0 && head_reg == TW'(gi)) || (ret1 && head1 == TW'(gi));
    assign hit_wr   = (acc0 && wa0 == TW'(gi)) || (acc1 && wa1 == TW'(gi));
    // Completions to entries that are not in flight are dropped.
    assign hit_cmpl = valid_reg[gi] &&
                      ((cmpl_en0_i && cmpl_tag0_i == TW'(gi)) ||
                       (cmpl_en1_i && cmpl_tag1_i == TW'(gi)));
    assign valid_next[gi] = hit_wr | (valid_reg[gi] & ~hit_ret);
    assign done_next[gi]  = hit_wr ? 1'b0 : (done_reg[gi] | hit_cmpl);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      valid_reg      <= '0;
      done_reg       <= '0;
      en_free_reg0_o <= 1'b0;
      en_free_reg1_o <= 1'b0;
      free_reg0_o    <= '0;
      free_reg1_o    <= '0;
    end else begin
      valid_reg <= valid_next;
      done_reg  <= done_next;
      tail_reg  <= tail_reg + TW'(acc0) + TW'(acc1);
      head_reg  <= head_reg + TW'(ret0) + TW'(ret1);
      count_reg <= count_reg + CW'(acc0) + CW'(acc1) - CW'(ret0) - CW'(ret1);
      // Enables pulse for one cycle; the preg values hold between retirements.
      en_free_reg0_o <= ret0 & has_old_reg[head_reg];
      en_free_reg1_o <= ret1 & has_old_reg[head1];
      if (ret0) free_reg0_o <= old_dest_reg[head_reg];
      if (ret1) free_reg1_o <= old_dest_reg[head1];
    end
  end

  // Payload storage needs no reset: it is only read behind a valid entry.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (acc0) begin
        has_old_reg[wa0]  <= has_old0_i;
        old_dest_reg[wa0] <= old_dest0_i;
      end
      if (acc1) begin
        has_old_reg[wa1]  <= has_old1_i;
        old_dest_reg[wa1] <= old_dest1_i;
      end
    end
  end

endmodule

// File: tb/tb_retire_unit.sv
// Testbench for retire_unit: directed scenarios plus a randomized phase,
// all checked against an in-order queue model of the buffer.
module tb_retire_unit;
  localparam int D  = 16;
  localparam int NP = 64;
  localparam int TW = 4;
  localparam int PW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, alloc0, alloc1, has_old0, has_old1;
  logic [PW-1:0] old_dest0, old_dest1;
  logic          cmpl_en0, cmpl_en1;
  logic [TW-1:0] cmpl_tag0, cmpl_tag1;
  logic [TW-1:0] tag0, tag1;
  logic          rob_full, rob_empty, en_free0, en_free1;
  logic [PW-1:0] free0, free1;

  retire_unit #(.NUM_P_REGS(NP), .ROB_DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst),
    .alloc0_i(alloc0), .alloc1_i(alloc1),
    .has_old0_i(has_old0), .has_old1_i(has_old1),
    .old_dest0_i(old_dest0), .old_dest1_i(old_dest1),
    .cmpl_en0_i(cmpl_en0), .cmpl_en1_i(cmpl_en1),
    .cmpl_tag0_i(cmpl_tag0), .cmpl_tag1_i(cmpl_tag1),
    .tag0_o(tag0), .tag1_o(tag1),
    .rob_full_o(rob_full), .rob_empty_o(rob_empty),
    .en_free_reg0_o(en_free0), .en_free_reg1_o(en_free1),
    .free_reg0_o(free0), .free_reg1_o(free1)
  );

  // Reference model: in-flight entries in program order.
  typedef struct {
    int tag;
    bit has_old;
    int dest;
    bit done;
  } ent_t;

  ent_t mq[$];
  int   next_tag;
  bit   exp_en0, exp_en1;
  int   exp_f0, exp_f1;
  int   fq[$];      // frees observed on the DUT, in output order
  int   tests = 0;
  int   fails = 0;

  task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  // Tag of the nth entry still waiting for completion, or -1.
  function automatic int pending(int nth);
    int n = 0;
    foreach (mq[k]) begin
      if (!mq[k].done) begin
        if (n == nth) return mq[k].tag;
        n++;
      end
    end
    return -1;
  endfunction

  // One clock cycle: starts and ends just after a falling edge.
  task automatic cycle(bit a0, bit a1, bit h0, int d0, bit h1, int d1,
                       bit c0, int t0, bit c1, int t1);
    ent_t e;
    bit   full, r0, r1;
    alloc0 = a0; alloc1 = a1;
    has_old0 = h0; has_old1 = h1;
    old_dest0 = d0[PW-1:0]; old_dest1 = d1[PW-1:0];
    cmpl_en0 = c0; cmpl_en1 = c1;
    cmpl_tag0 = t0[TW-1:0]; cmpl_tag1 = t1[TW-1:0];
    #1;
    full = mq.size() > D - 2;
    chk("full",  32'(rob_full),  32'(full));
    chk("empty", 32'(rob_empty), 32'(mq.size() == 0));
    chk("tag0",  32'(tag0), 32'(next_tag));
    chk("tag1",  32'(tag1), 32'((next_tag + int'(a0)) % D));
    @(posedge clk);
    r0 = mq.size() >= 1 && mq[0].done;
    r1 = r0 && mq.size() >= 2 && mq[1].done;
    exp_en0 = r0 && mq[0].has_old;
    exp_en1 = r1 && mq[1].has_old;
    if (r0) exp_f0 = mq[0].dest;
    if (r1) exp_f1 = mq[1].dest;
    if (r0) void'(mq.pop_front());
    if (r1) void'(mq.pop_front());
    foreach (mq[k])
      if ((c0 && mq[k].tag == t0) || (c1 && mq[k].tag == t1)) mq[k].done = 1'b1;
    if (!full) begin
      if (a0) begin
        e.tag = next_tag; e.has_old = h0; e.dest = d0 % NP; e.done = 1'b0;
        mq.push_back(e);
        next_tag = (next_tag + 1) % D;
      end
      if (a1) begin
        e.tag = next_tag; e.has_old = h1; e.dest = d1 % NP; e.done = 1'b0;
        mq.push_back(e);
        next_tag = (next_tag + 1) % D;
      end
    end
    #1;
    chk("en_free0", 32'(en_free0), 32'(exp_en0));
    chk("en_free1", 32'(en_free1), 32'(exp_en1));
    chk("free0",    32'(free0),    32'(exp_f0));
    chk("free1",    32'(free1),    32'(exp_f1));
    if (en_free0) fq.push_back(int'(free0));
    if (en_free1) fq.push_back(int'(free1));
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset with arbitrary traffic on the inputs: reset must win.
  task automatic do_reset();
    rst = 1'b1;
    alloc0 = 1'b1; alloc1 = 1'b1; has_old0 = 1'b1; has_old1 = 1'b1;
    cmpl_en0 = 1'b1; cmpl_en1 = 1'b1;
    cmpl_tag0 = TW'($urandom); cmpl_tag1 = TW'($urandom);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    next_tag = 0;
    exp_en0 = 0; exp_en1 = 0; exp_f0 = 0; exp_f1 = 0;
    chk("rst_en_free0", 32'(en_free0), 32'(0));
    chk("rst_en_free1", 32'(en_free1), 32'(0));
    chk("rst_free0",    32'(free0),    32'(0));
    chk("rst_free1",    32'(free1),    32'(0));
    alloc0 = 1'b0; alloc1 = 1'b0; cmpl_en0 = 1'b0; cmpl_en1 = 1'b0;
    @(negedge clk);
  endtask

  // Complete the oldest waiting entries until the buffer empties.
  task automatic drain();
    int p0, p1;
    for (int i = 0; i < 40 && mq.size() != 0; i++) begin
      p0 = pending(0);
      p1 = pending(1);
      cycle(0, 0, 0, 0, 0, 0, p0 >= 0, (p0 < 0) ? 0 : p0, p1 >= 0, (p1 < 0) ? 0 : p1);
    end
    chk("drain_count", 32'(mq.size()), 32'(0));
  endtask

  int saved_tag;
  int exp_order[$];
  int p, k0, k1, t0, t1;
  bit c0, c1;

  initial begin
    rst = 1'b0;
    alloc0 = 0; alloc1 = 0; has_old0 = 0; has_old1 = 0;
    old_dest0 = '0; old_dest1 = '0;
    cmpl_en0 = 0; cmpl_en1 = 0; cmpl_tag0 = '0; cmpl_tag1 = '0;
    @(negedge clk);
    do_reset();

    // Post-reset status and a simple pair through retire.
    alloc0 = 1'b1;
    #1;
    chk("rst_empty", 32'(rob_empty), 32'(1));
    chk("rst_full",  32'(rob_full),  32'(0));
    chk("rst_tag0",  32'(tag0),      32'(0));
    chk("rst_tag1",  32'(tag1),      32'(1));
    cycle(1, 1, 1, 5, 1, 6, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    idle();
    chk("pair_free0", 32'(free0), 32'(5));
    chk("pair_free1", 32'(free1), 32'(6));
    chk("pair_en1",   32'(en_free1), 32'(1));
    chk("pair_empty", 32'(rob_empty), 32'(1));

    // Out-of-order completion: younger first, then both retire together.
    cycle(1, 1, 1, 7, 1, 8, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    idle();
    chk("ooo_no_free", 32'(en_free0), 32'(0));
    cycle(0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
    idle();
    chk("ooo_free0", 32'(free0), 32'(7));
    chk("ooo_free1", 32'(free1), 32'(8));

    // Entry without an old preg still retires; its partner frees on port 1.
    cycle(1, 1, 0, 9, 1, 10, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 4, 1, 5);
    idle();
    chk("noold_en0",   32'(en_free0), 32'(0));
    chk("noold_en1",   32'(en_free1), 32'(1));
    chk("noold_free1", 32'(free1),    32'(10));

    // Fill to 15 entries, then confirm dispatch is ignored while full.
    for (int i = 0; i < 7; i++) cycle(1, 1, 1, 20 + i, 1, 40 + i, 0, 0, 0, 0);
    cycle(1, 0, 1, 30, 0, 0, 0, 0, 0, 0);
    chk("fill_full", 32'(rob_full), 32'(1));
    saved_tag = next_tag;
    cycle(1, 1, 1, 60, 1, 61, 0, 0, 0, 0);
    chk("full_tag_hold", 32'(tag0), 32'(saved_tag));
    cycle(0, 0, 0, 0, 0, 0, 1, mq[0].tag, 1, mq[1].tag);
    idle();
    #1;
    chk("full_drop", 32'(rob_full), 32'(0));
    @(negedge clk);
    drain();

    // 40 single alloc/retire pairs: pointers wrap, frees in allocation order.
    fq.delete();
    exp_order.delete();
    for (int i = 0; i < 40; i++) begin
      p = pending(0);
      exp_order.push_back((i * 3 + 1) % NP);
      cycle(1, 0, 1, (i * 3 + 1) % NP, 0, 0, p >= 0, (p < 0) ? 0 : p, 0, 0);
    end
    drain();
    chk("wrap_free_count", 32'(fq.size()), 32'(40));
    for (int i = 0; i < 40 && i < fq.size(); i++)
      chk($sformatf("wrap_order%0d", i), 32'(fq[i]), 32'(exp_order[i]));

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      c0 = 0; c1 = 0; t0 = $urandom % D; t1 = $urandom % D;
      if (mq.size() != 0 && ($urandom % 3) != 0) begin
        k0 = $urandom_range(0, mq.size() - 1);
        c0 = 1; t0 = mq[k0].tag;
      end else c0 = (($urandom % 4) == 0);
      if (mq.size() != 0 && ($urandom % 2) != 0) begin
        k1 = $urandom_range(0, mq.size() - 1);
        c1 = 1; t1 = mq[k1].tag;
      end
      cycle(($urandom % 3) != 0, ($urandom % 2) != 0,
            ($urandom % 4) != 0, $urandom % NP,
            ($urandom % 4) != 0, $urandom % NP, c0, t0, c1, t1);
    end
    drain();

    // Reset with six completed entries waiting at the head.
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 11 + i, 1, 21 + i, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, mq[5].tag, 1, mq[4].tag);
    cycle(0, 0, 0, 0, 0, 0, 1, mq[3].tag, 1, mq[2].tag);
    cycle(0, 0, 0, 0, 0, 0, 1, mq[1].tag, 1, mq[0].tag);
    do_reset();
    #1;
    chk("rst6_empty", 32'(rob_empty), 32'(1));
    chk("rst6_tag0",  32'(tag0),      32'(0));
    @(negedge clk);
    idle();
    chk("rst6_no_free", 32'(en_free0), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/retire_unit.md
RETIRE_UNIT -- requirements
Module: retire_unit

Interface
REQ-001 SHALL have parameter NUM_P_REGS, default 64, physical register count; preg fields are $clog2(NUM_P_REGS) bits wide.
REQ-002 SHALL have parameter ROB_DEPTH, default 16, in-flight entry count (power of two); tag fields are $clog2(ROB_DEPTH) bits wide.
REQ-003 SHALL have port clk_i, input, 1 bit: the only clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have ports alloc0_i, alloc1_i, input, 1 bit each: dispatch slot 0 and slot 1 request an entry.
REQ-006 SHALL have ports has_old0_i, has_old1_i, input, 1 bit each: the slot has an old destination preg to free at retire (0 for rd=x0 or no destination).
REQ-007 SHALL have ports old_dest0_i, old_dest1_i, input, preg width: the renamer's superseded preg for each slot.
REQ-008 SHALL have ports cmpl_en0_i, cmpl_en1_i, input, 1 bit, and cmpl_tag0_i, cmpl_tag1_i, input, tag width: execution completion reports.
REQ-009 SHALL have ports tag0_o, tag1_o, output, tag width: entry tags assigned to slot 0 and slot 1 this cycle.
REQ-010 SHALL have ports rob_full_o and rob_empty_o, output, 1 bit each.
REQ-011 SHALL have ports en_free_reg0_o, en_free_reg1_o, output, 1 bit, and free_reg0_o, free_reg1_o, output, preg width: the free requests wired directly to the renamer's free inputs.

Function
REQ-012 SHALL keep a circular entry array with head and tail pointers modulo ROB_DEPTH and a count in 0..ROB_DEPTH; each entry holds valid, done, has_old and old_dest.
REQ-013 SHALL drive rob_full_o combinationally high when count > ROB_DEPTH-2, so a two-wide dispatch is never partially accepted.
REQ-014 SHALL drive rob_empty_o combinationally high when count == 0.
REQ-015 SHALL ignore alloc0_i and alloc1_i entirely while rob_full_o is high.
REQ-016 SHALL, when not full, write slot 0 at tail and slot 1 at tail+1, with done=0.
REQ-017 SHALL write slot 1 at tail when alloc1_i is high without alloc0_i.
REQ-018 SHALL advance tail by the number of accepted slots.
REQ-019 SHALL drive tag0_o = tail and tag1_o = tail + alloc0_i (mod ROB_DEPTH) combinationally.
REQ-020 SHALL, for each cmpl_en high, set done of the entry at its tag; a report to an invalid entry is ignored; both ports naming one tag is legal.
REQ-021 SHALL retire in order at each edge: head retires if valid and done; head+1 retires only if head retires and head+1 is valid and done; at most two retire per cycle.
REQ-022 SHALL clear valid for each retired entry and advance head by the retire count.
REQ-023 SHALL update count = count + accepted − retired.
REQ-024 SHALL evaluate retirement on pre-edge state, so a completion written at edge N makes that entry retirable at edge N+1 at the earliest.
REQ-025 SHALL evaluate fullness on pre-edge count, so an allocation in the same cycle as a retirement does not use the freed slots.
REQ-026 SHALL register the free outputs: the edge that retires head sets en_free_reg0_o = head.has_old and free_reg0_o = head.old_dest.
REQ-027 SHALL, at that same edge, set en_free_reg1_o and free_reg1_o likewise from head+1 when it retires.
REQ-028 SHALL deassert the free enables and hold the free preg values when no retirement occurs at an edge.

Reset
REQ-029 SHALL, while rst_i is high at an edge, set head=tail=count=0, clear all valid and done bits, set en_free_reg0_o=en_free_reg1_o=0 and free_reg0_o=free_reg1_o=0.
REQ-030 SHALL give rst_i priority over allocation, completion and retirement in the same cycle; reset mid-operation discards in-flight entries without issuing frees.
REQ-031 SHALL present rob_empty_o=1, rob_full_o=0, tag0_o=0 and tag1_o=1 (with alloc0_i=1) after reset.

Verification
REQ-032 SHALL be verified by: reset, then alloc both slots with old 5 and 6 -> tags 0,1; complete tag 0 and tag 1 -> next edge en_free_reg0/1=1, free_reg0=5, free_reg1=6, then rob_empty_o=1.
REQ-033 SHALL be verified by: out-of-order completion, with tag 1 complete first -> no free; after tag 0 completes -> both freed in one cycle, in order.
REQ-034 SHALL be verified by: has_old0_i=0 on entry 0 -> at retire en_free_reg0_o=0, head still advances, and entry 1 frees on port 1.
REQ-035 SHALL be verified by: filling to count=15 -> rob_full_o=1 and alloc ignored (tags unchanged); retiring two entries -> full drops next cycle.
REQ-036 SHALL be verified by: 40 alloc/retire pairs -> head and tail wrap past 15->0 and free order matches allocation order.
REQ-037 SHALL be verified by: rst_i high with 6 valid, done entries -> no free enables; after reset rob_empty_o=1 and tag0_o=0.
